muldiv_unit: RTL

//  Iterative RV32M multiply/divide execution unit. Consumes the two operands

---
 rtl/muldiv_unit.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide.
// Ports: clock, reset_n, start/funct3/op_a/op_b/rd_in in; busy/done/result/rd_out out.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  op_a,
  input  logic [XLEN-1:0]  op_b,
  input  logic [TAG_W-1:0] rd_in,
  output logic             busy,
  output logic             done,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] rd_out
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_funct3;
  logic [TAG_W-1:0] r_tag;
  logic             r_div;
  logic             r_neg;
  logic             r_rneg;
  logic [XLEN-1:0]  r_hi;
  logic [XLEN-1:0]  r_lo;
  logic [XLEN-1:0]  r_op;

  logic             w_a_sgn;
  logic             w_b_sgn;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [XLEN-1:0]  w_mag_a;
  logic [XLEN-1:0]  w_mag_b;
  logic             w_div0;
  logic             w_ovf;
  logic [XLEN-1:0]  w_fast_res;

  logic [XLEN:0]    w_add;
  logic [XLEN-1:0]  w_mul_hi;
  logic [XLEN-1:0]  w_mul_lo;
  logic [XLEN:0]    w_rem_sh;
  logic             w_fits;
  logic [XLEN-1:0]  w_sub;
  logic [XLEN-1:0]  w_div_hi;
  logic [XLEN-1:0]  w_div_lo;
  logic [XLEN-1:0]  w_hi_n;
  logic [XLEN-1:0]  w_lo_n;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]  w_quo;
  logic [XLEN-1:0]  w_rem;
  logic [XLEN-1:0]  w_final;
  logic             w_last;

  // Operand decode at accept time
  assign w_a_sgn = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                   (funct3 == 3'b010) || (funct3 == 3'b100) ||
                   (funct3 == 3'b110);
  assign w_b_sgn = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
  assign w_a_neg = w_a_sgn & op_a[XLEN-1];
  assign w_b_neg = w_b_sgn & op_b[XLEN-1];
  assign w_mag_a = w_a_neg ? (~op_a + 1'b1) : op_a;
  assign w_mag_b = w_b_neg ? (~op_b + 1'b1) : op_b;

  assign w_div0 = funct3[2] && (op_b == '0);
  assign w_ovf  = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                  (op_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                  (op_b == '1);

  // Divide-by-zero: quotient all ones, remainder = dividend.
  // Overflow: quotient = dividend (0x80..0), remainder 0.
  always_comb begin
    w_fast_res = '0;
    if (w_div0)
      w_fast_res = funct3[1] ? op_a : '1;
    else
      w_fast_res = funct3[1] ? '0 : op_a;
  end

  // Multiply step: {hi,lo} shifts right, lo starts as the multiplier
  assign w_add    = {1'b0, r_hi} +
                    (r_lo[0] ? {1'b0, r_op} : '0);
  assign w_mul_hi = w_add[XLEN:1];
  assign w_mul_lo = {w_add[0], r_lo[XLEN-1:1]};

  // Restoring divide step: lo holds dividend bits, becomes quotient
  assign w_rem_sh = {r_hi, r_lo[XLEN-1]};
  assign w_fits   = (w_rem_sh >= {1'b0, r_op});
  // True difference is below the divisor, so the low XLEN bits suffice
  assign w_sub    = w_rem_sh[XLEN-1:0] - r_op;
  assign w_div_hi = w_fits ? w_sub : w_rem_sh[XLEN-1:0];
  assign w_div_lo = {r_lo[XLEN-2:0], w_fits};

  assign w_hi_n = r_div ? w_div_hi : w_mul_hi;
  assign w_lo_n = r_div ? w_div_lo : w_mul_lo;

  assign w_prod   = {w_hi_n, w_lo_n};
  assign w_prod_s = r_neg ? (~w_prod + 1'b1) : w_prod;
  assign w_quo    = r_neg ? (~w_lo_n + 1'b1) : w_lo_n;
  assign w_rem    = r_rneg ? (~w_hi_n + 1'b1) : w_hi_n;

  always_comb begin
    w_final = '0;
    unique case (1'b1)
      (r_funct3 == 3'b000): w_final = w_prod_s[XLEN-1:0];
      (r_funct3[2] == 1'b0 && r_funct3 != 3'b000):
        w_final = w_prod_s[2*XLEN-1:XLEN];
      (r_funct3[2:1] == 2'b10): w_final = w_quo;
      (r_funct3[2:1] == 2'b11): w_final = w_rem;
      default: w_final = '0;
    endcase
  end

  assign w_last = (r_cnt == CW'(XLEN-1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_funct3 <= '0;
      r_tag    <= '0;
      r_div    <= 1'b0;
      r_neg    <= 1'b0;
      r_rneg   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_op     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      rd_out   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_funct3 <= funct3;
            r_tag    <= rd_in;
            r_div    <= funct3[2];
            r_neg    <= w_a_neg ^ w_b_neg;
            r_rneg   <= w_a_neg;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= funct3[2] ? w_mag_a : w_mag_b;
            r_op     <= funct3[2] ? w_mag_b : w_mag_a;
            if (w_div0 || w_ovf) begin
              result  <= w_fast_res;
              rd_out  <= rd_in;
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              busy    <= 1'b1;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_hi  <= w_hi_n;
          r_lo  <= w_lo_n;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            result  <= w_final;
            rd_out  <= r_tag;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
